// File: rtl/picomips_display_driver.sv
`default_nettype none
// ============================================================================
//  Module   : picomips_display_driver
//  Purpose  : Shows the picoMIPS 8-bit display bus on a 4-digit, time-
//             multiplexed, active-low seven-segment display as
//             sign / hundreds / tens / ones. The value is read as unsigned or
//             as two's complement. A sequential double-dabble engine converts
//             each new value to decimal. The display keeps showing the last
//             committed result until a conversion finishes.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    SCAN_DIV     clk cycles per digit slot (>= 2)
//  Ports
//    clk          system clock, rising-edge active
//    reset        synchronous, active-low reset
//    value[7:0]   processor display bus (already synchronous to clk)
//    signed_mode  1 = interpret value as two's complement
//    seg[6:0]     active-low segments {g,f,e,d,c,b,a}, registered
//    an[3:0]      active-low one-hot digit enables
//                 bit0 ones, bit1 tens, bit2 hundreds, bit3 sign; registered
//    busy         conversion in progress, registered
//    upd          one-cycle pulse when a new result reaches the display
// ============================================================================
module picomips_display_driver #(
   parameter int SCAN_DIV = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] value,
   input  logic       signed_mode,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       busy,
   output logic       upd
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_CONV   = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;

   localparam logic [3:0] ITER_LAST = 4'd7;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_ZERO  = 7'b1000000;
   localparam logic [3:0] AN_RESET  = 4'b1110;

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   logic [1:0]         state_q,    state_d;
   logic [8:0]         cap_q,      cap_d;       // last captured {signed_mode, value}
   logic               neg_pend_q, neg_pend_d;  // sign of the value being converted
   logic [7:0]         bin_q,      bin_d;       // binary half of the shift register
   logic [11:0]        bcd_q,      bcd_d;       // BCD half of the shift register
   logic [3:0]         iter_q,     iter_d;
   logic               busy_q,     busy_d;
   logic               upd_q,      upd_d;

   logic [3:0]         disp_hun_q, disp_hun_d;
   logic [3:0]         disp_ten_q, disp_ten_d;
   logic [3:0]         disp_one_q, disp_one_d;
   logic               disp_neg_q, disp_neg_d;

   logic [PRESC_W-1:0] presc_q,    presc_d;
   logic [1:0]         idx_q,      idx_d;
   logic [3:0]         an_q,       an_d;
   logic [6:0]         seg_q,      seg_d;

   // ------------------------------------------------------------------------
   // Input view: sign and magnitude of the incoming value
   // ------------------------------------------------------------------------
   logic       in_neg;
   logic [7:0] in_mag;
   logic       in_changed;

   // Negating 8'h80 gives 8'h80, which is 128 read as unsigned. The magnitude
   // therefore always fits in 8 bits, and the 9th bit of the negation is
   // never needed.
   assign in_neg     = signed_mode & value[7];
   assign in_mag     = in_neg ? (~value + 8'd1) : value;
   assign in_changed = ({signed_mode, value} != cap_q);

   // ------------------------------------------------------------------------
   // One double-dabble step: adjust every BCD nibble >= 5 by +3, then
   // shift {bcd, bin} left by one bit.
   // ------------------------------------------------------------------------
   logic [11:0] bcd_adj;
   logic [11:0] bcd_step;
   logic [7:0]  bin_step;

   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 3; i++) begin
         if (bcd_q[i*4 +: 4] >= 4'd5) begin
            bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
         end
      end
      bcd_step = (bcd_adj << 1) | {11'd0, bin_q[7]};
      bin_step = bin_q << 1;
   end

   // ------------------------------------------------------------------------
   // Conversion FSM
   // ------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      cap_d      = cap_q;
      neg_pend_d = neg_pend_q;
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      iter_d     = iter_q;
      busy_d     = busy_q;
      upd_d      = 1'b0;
      disp_hun_d = disp_hun_q;
      disp_ten_d = disp_ten_q;
      disp_one_d = disp_one_q;
      disp_neg_d = disp_neg_q;

      case (state_q)
         ST_IDLE: begin
            // The pair is only compared here. A change that arrives during
            // CONV or COMMIT is seen on the first IDLE cycle, so the last
            // stable input is always the one displayed.
            if (in_changed) begin
               cap_d      = {signed_mode, value};
               neg_pend_d = in_neg;
               bin_d      = in_mag;
               bcd_d      = 12'd0;
               iter_d     = 4'd0;
               busy_d     = 1'b1;
               state_d    = ST_CONV;
            end
         end

         ST_CONV: begin
            bcd_d = bcd_step;
            bin_d = bin_step;
            if (iter_q == ITER_LAST) begin
               iter_d  = 4'd0;
               state_d = ST_COMMIT;
            end else begin
               iter_d  = iter_q + 4'd1;
            end
         end

         ST_COMMIT: begin
            disp_hun_d = bcd_q[11:8];
            disp_ten_d = bcd_q[7:4];
            disp_one_d = bcd_q[3:0];
            disp_neg_d = neg_pend_q;
            upd_d      = 1'b1;
            busy_d     = 1'b0;
            state_d    = ST_IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Digit scan and segment decode
   // ------------------------------------------------------------------------
   function automatic logic [6:0] digit_seg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   always_comb begin
      presc_d = presc_q;
      idx_d   = idx_q;
      if (presc_q == PRESC_LAST) begin
         presc_d = '0;
         idx_d   = idx_q + 2'd1;
      end else begin
         presc_d = presc_q + 1'b1;
      end

      // an/seg are built from the current index and display registers, so
      // they follow both the index and a commit one cycle later.
      an_d = ~(4'b0001 << idx_q);

      case (idx_q)
         2'd0: seg_d = digit_seg(disp_one_q);
         2'd1: seg_d = ((disp_hun_q == 4'd0) && (disp_ten_q == 4'd0))
                       ? SEG_BLANK : digit_seg(disp_ten_q);
         2'd2: seg_d = (disp_hun_q == 4'd0) ? SEG_BLANK : digit_seg(disp_hun_q);
         default: seg_d = disp_neg_q ? SEG_MINUS : SEG_BLANK;
      endcase
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cap_q      <= 9'd0;
         neg_pend_q <= 1'b0;
         bin_q      <= 8'd0;
         bcd_q      <= 12'd0;
         iter_q     <= 4'd0;
         busy_q     <= 1'b0;
         upd_q      <= 1'b0;
         disp_hun_q <= 4'd0;
         disp_ten_q <= 4'd0;
         disp_one_q <= 4'd0;
         disp_neg_q <= 1'b0;
         presc_q    <= '0;
         idx_q      <= 2'd0;
         an_q       <= AN_RESET;
         seg_q      <= SEG_ZERO;
      end else begin
         state_q    <= state_d;
         cap_q      <= cap_d;
         neg_pend_q <= neg_pend_d;
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         iter_q     <= iter_d;
         busy_q     <= busy_d;
         upd_q      <= upd_d;
         disp_hun_q <= disp_hun_d;
         disp_ten_q <= disp_ten_d;
         disp_one_q <= disp_one_d;
         disp_neg_q <= disp_neg_d;
         presc_q    <= presc_d;
         idx_q      <= idx_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
      end
   end

   assign seg  = seg_q;
   assign an   = an_q;
   assign busy = busy_q;
   assign upd  = upd_q;

endmodule
`default_nettype wire

// File: tb/tb_picomips_display_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_picomips_display_driver
//  Purpose  : Randomised, scoreboard-based bench for picomips_display_driver.
//             Every accepted input change queues its expected decimal
//             display. A negedge monitor pops one entry per upd pulse. On
//             every cycle it also checks an, seg, busy and upd against a
//             frame-position model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_picomips_display_driver;

   localparam int SD = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] value = 8'd0;
   logic       signed_mode = 1'b0;
   logic [6:0] seg;
   logic [3:0] an;
   logic       busy;
   logic       upd;

   picomips_display_driver #(.SCAN_DIV(SD)) dut (
      .clk         (clk),
      .reset       (reset),
      .value       (value),
      .signed_mode (signed_mode),
      .seg         (seg),
      .an          (an),
      .busy        (busy),
      .upd         (upd)
   );

   always #5 clk = ~clk;

   typedef struct {
      int hun;
      int ten;
      int one;
      bit neg;
   } disp_t;

   disp_t exp_q[$];
   int    errors = 0;
   int    checks = 0;

   // Reference model: decimal digits of the value as the user should see it.
   function automatic disp_t model(input bit s, input logic [7:0] v);
      disp_t d;
      int    m;
      d.neg = s && v[7];
      m     = d.neg ? (256 - int'(v)) : int'(v);
      d.hun = m / 100;
      d.ten = (m / 10) % 10;
      d.one = m % 10;
      return d;
   endfunction

   function automatic logic [6:0] pat(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'bxxxxxxx;
      endcase
   endfunction

   function automatic logic [6:0] exp_seg(input int idx, input disp_t d);
      case (idx)
         0: return pat(d.one);
         1: return (d.hun == 0 && d.ten == 0) ? 7'b1111111 : pat(d.ten);
         2: return (d.hun == 0) ? 7'b1111111 : pat(d.hun);
         default: return d.neg ? 7'b0111111 : 7'b1111111;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Frame position: n = edges since the last reset edge
   // ------------------------------------------------------------------------
   int n = 0;
   bit seen_rst = 1'b0;

   always @(posedge clk) begin
      if (!reset) begin
         n        <= 0;
         seen_rst <= 1'b1;
      end else begin
         n        <= n + 1;
      end
   end

   // ------------------------------------------------------------------------
   // Monitor
   // ------------------------------------------------------------------------
   disp_t cur;
   int    busy_len = 0;

   always @(negedge clk) begin
      int         idx;
      logic [3:0] exp_an;
      bit         fell;
      disp_t      e;
      if (seen_rst) begin
         if (n == 0) begin
            cur      = '{hun: 0, ten: 0, one: 0, neg: 1'b0};
            busy_len = 0;
         end
         // an/seg are registered from the index of the previous cycle.
         idx    = (n == 0) ? 0 : (((n - 1) / SD) % 4);
         exp_an = ~(4'b0001 << idx);
         check("an", {28'd0, an}, {28'd0, exp_an});
         check("seg", {25'd0, seg}, {25'd0, exp_seg(idx, cur)});

         fell = !busy && (busy_len > 0);
         if (fell) check("busy_len", busy_len, 32'd9);
         check("upd", {31'd0, upd}, {31'd0, fell});
         if (busy === 1'b1) busy_len++;
         else               busy_len = 0;

         if (upd === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL upd_unexpected: got upd=1, expected no commit at %0t", $time);
            end else begin
               e   = exp_q.pop_front();
               cur = e;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   logic [8:0] last_pair = 9'd0;

   task automatic tick(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   // Queue an expected result only when the pair differs from the last
   // accepted one; an unchanged pair starts no conversion.
   task automatic apply(input logic [7:0] v, input logic s);
      if ({s, v} != last_pair) begin
         exp_q.push_back(model(s, v));
         last_pair = {s, v};
      end
      value       = v;
      signed_mode = s;
   endtask

   initial begin
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
      tick(6);

      apply(8'd173, 1'b0); tick(30);
      apply(8'h80, 1'b1);  tick(30);
      apply(8'hFF, 1'b1);  tick(30);
      apply(8'hFF, 1'b0);  tick(30);
      apply(8'h7F, 1'b1);  tick(30);
      apply(8'h00, 1'b1);  tick(30);
      apply(8'h00, 1'b0);  tick(30);

      // A change two cycles into a conversion.
      apply(8'd5, 1'b0);   tick(2);
      apply(8'd200, 1'b0); tick(40);

      // Reset lands on the 4th CONV edge. The value stays nonzero, so a
      // fresh capture follows the release.
      apply(8'd77, 1'b0);  tick(4);
      reset = 1'b0;
      exp_q.delete();
      tick(2);
      reset     = 1'b1;
      last_pair = 9'd0;
      apply(value, signed_mode);
      tick(30);

      for (int t = 0; t < 60; t++) begin
         apply(8'($urandom), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 2) == 0) begin
            tick($urandom_range(1, 10));
            apply(8'($urandom), 1'($urandom_range(0, 1)));
         end
         tick($urandom_range(22, 40));
      end

      tick(40);
      check("pending_results", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/picomips_display_driver.md
# picomips_display_driver

Downstream consumer of the picoMIPS `display[7:0]` output. It converts the 8-bit result to decimal with a sequential double-dabble engine, honouring an unsigned or two's-complement view. It then drives a 4-digit, time-multiplexed, active-low seven-segment display: sign, hundreds, tens and ones. It sits between the processor core and the board's LED pins and is the only path by which processor results reach the user.

## Interface
- `SCAN_DIV`, default 50000: clk cycles per digit slot, legal range ≥ 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled only on the `clk` rising edge.
- `value`  in  8  processor display bus; sampled directly, already synchronous to `clk`.
- `signed_mode`  in  1  1 = interpret `value` as two's complement.
- `seg`  out  7  active-low segments, bit order {g,f,e,d,c,b,a}, registered.
- `an`  out  4  active-low digit enables, one-hot; bit0 = ones, bit1 = tens, bit2 = hundreds, bit3 = sign; registered.
- `busy`  out  1  conversion in progress, registered.
- `upd`  out  1  one-cycle pulse when a new result is committed to the display, registered.

## Operation
- **IDLE.** Every cycle, compare {`signed_mode`,`value`} against the captured pair.
  - If they differ: capture both, load the magnitude into the shift register, clear the BCD field, set `busy`, enter CONV.
- **Magnitude.** If `signed_mode` and `value[7]`, magnitude = (~value + 1) taken as a 9-bit unsigned value, so 8'h80 gives 128. Otherwise magnitude = `value`. The negative flag is captured alongside.
- **CONV.** Runs exactly 8 iterations, one per cycle. Each iteration:
  - add 3 to every BCD nibble ≥ 5;
  - shift {BCD[11:0], bin[7:0]} left by 1.
  - The 4-bit iteration counter wraps from 7 to COMMIT.
- **COMMIT.** Copy the BCD digits and negative flag into the display registers, pulse `upd`, clear `busy`, return to IDLE.
- **Input changes during CONV/COMMIT.** Ignored. The IDLE compare on the following cycle picks up the latest pair, so the final stable input is always displayed. Intermediate BCD values are never visible.
- **Blanking rules.**
  - Hundreds is blank if it is 0.
  - Tens is blank if both hundreds and tens are 0.
  - Ones is always lit.
  - The sign digit shows minus (`seg` = 0111111) if negative, otherwise blank (1111111).
- **Digit patterns.**
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- **Scan.**
  - The prescaler counts 0..`SCAN_DIV`-1 and wraps to 0.
  - On each wrap, the 2-bit digit index advances 0→1→2→3→0.
  - `an`/`seg` are registered every cycle from the current index and the display registers. They therefore lag the index and any commit by one cycle.
  - Exactly one `an` bit is low at all times after reset.

## Timing
- **Reset (`reset` = 0 at an edge)** forces:
  - state IDLE; captured pair = {0, 8'h00}; display digits 0/0/0; negative = 0;
  - prescaler 0; index 0;
  - `an` = 1110, `seg` = 1000000 (so "   0" is displayed), `busy` = 0, `upd` = 0.
- **Reset mid-conversion** aborts the conversion. No `upd` is produced and the display registers return to their reset values.
- **Conversion latency.**
  - Input pair differs at capture edge k.
  - `busy` = 1 from after edge k until edge k+9.
  - Display registers and `upd` = 1 take effect after edge k+9. `upd` lasts one cycle.
  - `seg` reflects the new result after edge k+10.
  - The earliest next capture is edge k+10. Worst-case result-to-display latency is 20 cycles.
- **Release with nonzero `value`.** If `value` ≠ 0 when reset releases, capture occurs on the first edge with `reset` = 1.
- **Scan period.** Each digit is displayed for `SCAN_DIV` cycles; the full frame is 4×`SCAN_DIV` cycles. The scan is unaffected by conversions.

## Test plan
- **Reset:** hold `reset` = 0 for 2 cycles with `value` = 0 → `an` = 1110, `seg` = 1000000, `busy` = 0, `upd` = 0. With `value` still 0 after release, no conversion starts.
- **Unsigned conversion:** `SCAN_DIV` = 4, `signed_mode` = 0, `value` = 173 → `busy` high for 9 cycles, then one `upd` pulse. Over one frame (4 slots of 4 cycles):
  - `an`/`seg` = 1110/0110000, 1101/1111000, 1011/1111001, 0111/1111111.
- **Signed conversions:**
  - `value` = 8'h80 → sign 0111111, hundreds 1111001, tens 0100100, ones 0000000.
  - `value` = 8'hFF → sign minus, hundreds and tens blank, ones 1111001.
  - `signed_mode` 1→0 with `value` = 8'hFF held → reconversion shows "255".
- **Input change during conversion:** `value` = 5, then `value` = 200 two cycles later → first `upd` shows 5. A second capture follows immediately, and a second `upd` shows 200 (hundreds 0100100, tens 1000000, ones 1000000). No other `upd` pulses occur.
- **Reset mid-conversion:** assert `reset` = 0 at the 4th CONV cycle → next cycle `busy` = 0, no `upd`, outputs at reset values.
- **Scan wrap:** `SCAN_DIV` = 4 over 20 cycles → `an` sequence 1110, 1101, 1011, 0111, 1110, each held 4 cycles, with exactly one bit low at all times.
